// File: rtl/fetch_unit.sv
// fetch_unit -- code-byte prefetcher with a 6-clock bus slot and a 2-entry FIFO.
//
// Each fetch slot (S0..S5) reads one code byte either from the internal ROM
// (EA=1 and address <= IROM_TOP) or from the external multiplexed bus
// (ALE / PSEN / P0 / P2). The byte and its address are pushed into a 2-entry
// FIFO at the edge ending S5; the consumer pops the head with out_ready.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   EA                    1 = internal ROM for addresses <= IROM_TOP
//   load, load_addr       flush FIFO, abort slot, restart fetch at load_addr
//   out_byte, out_addr    FIFO head byte and its address
//   out_valid, out_ready  head present / consumer accepts head
//   ALE, PSEN             address latch enable (high), program strobe (low)
//   p0_out, p0_oe, p0_in  multiplexed low address / code data
//   p2_out, p2_oe         high address
//   rom_addr, rom_rd,     internal ROM port; rom_data valid while rom_rd=1
//   rom_data
module fetch_unit #(
    parameter int unsigned SLOT_CLKS = 6,
    parameter logic [15:0] IROM_TOP  = 16'h0FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EA,
    input  logic        load,
    input  logic [15:0] load_addr,
    output logic [7:0]  out_byte,
    output logic [15:0] out_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ALE,
    output logic        PSEN,
    output logic [7:0]  p0_out,
    output logic        p0_oe,
    input  logic [7:0]  p0_in,
    output logic [7:0]  p2_out,
    output logic        p2_oe,
    output logic [15:0] rom_addr,
    output logic        rom_rd,
    input  logic [7:0]  rom_data
);

    // The slot FSM is hard-wired to six phases.
    if (SLOT_CLKS != 6) begin : g_slot_clks_check
        $error("fetch_unit supports only SLOT_CLKS = 6");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        int_q, int_d;      // slot mode latched at S0: 1 = internal ROM
    logic [7:0]  b0_q, b0_d, b1_q, b1_d;
    logic [15:0] a0_q, a0_d, a1_q, a1_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        int_cur;
    logic        in_slot;
    logic        early;
    logic        late;
    logic        pop;
    logic        push;
    logic [1:0]  cnt_pop;
    logic [7:0]  push_byte;

    // During S0 the mode is decided live from EA; afterwards the latched copy
    // is used so EA changes mid-slot have no effect.
    assign int_cur = (state_q == ST_S0) ? (EA && (addr_q <= IROM_TOP)) : int_q;
    assign in_slot = (state_q != ST_IDLE);
    assign early   = (state_q == ST_S0) || (state_q == ST_S1) || (state_q == ST_S2);
    assign late    = (state_q == ST_S3) || (state_q == ST_S4) || (state_q == ST_S5);

    assign ALE      = (state_q == ST_S0) || (state_q == ST_S1);
    assign PSEN     = !(late && !int_cur);
    assign p0_oe    = early && !int_cur;
    assign p0_out   = p0_oe ? addr_q[7:0] : 8'h00;
    assign p2_oe    = in_slot && !int_cur;
    assign p2_out   = p2_oe ? addr_q[15:8] : 8'h00;
    assign rom_rd   = late && int_cur;
    assign rom_addr = addr_q;

    assign out_valid = (cnt_q != 2'd0);
    assign out_byte  = b0_q;
    assign out_addr  = a0_q;

    assign pop       = out_valid && out_ready;
    assign push      = (state_q == ST_S5);
    assign push_byte = int_q ? rom_data : p0_in;

    // FIFO: pop shifts the second entry to the head, then a push lands in the
    // first free entry. load discards both.
    always_comb begin
        b0_d    = b0_q;
        a0_d    = a0_q;
        b1_d    = b1_q;
        a1_d    = a1_q;
        cnt_d   = cnt_q;
        cnt_pop = cnt_q - {1'b0, pop};
        if (load) begin
            cnt_d = 2'd0;
        end else begin
            if (pop) begin
                b0_d = b1_q;
                a0_d = a1_q;
            end
            if (push) begin
                if (cnt_pop == 2'd0) begin
                    b0_d = push_byte;
                    a0_d = addr_q;
                end else begin
                    b1_d = push_byte;
                    a1_d = addr_q;
                end
                cnt_d = cnt_pop + 2'd1;
            end else begin
                cnt_d = cnt_pop;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        int_d   = int_q;
        if (load) begin
            state_d = ST_IDLE;
            addr_d  = load_addr;
        end else begin
            case (state_q)
                ST_IDLE: if (cnt_q < 2'd2) state_d = ST_S0;
                ST_S0: begin
                    int_d   = int_cur;
                    state_d = ST_S1;
                end
                ST_S1: state_d = ST_S2;
                ST_S2: state_d = ST_S3;
                ST_S3: state_d = ST_S4;
                ST_S4: state_d = ST_S5;
                ST_S5: begin
                    addr_d  = addr_q + 16'd1;
                    // Back-to-back slot only if the FIFO still has room after this push.
                    state_d = (cnt_d < 2'd2) ? ST_S0 : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 16'h0000;
            int_q   <= 1'b0;
            b0_q    <= 8'h00;
            a0_q    <= 16'h0000;
            b1_q    <= 8'h00;
            a1_q    <= 16'h0000;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            int_q   <= int_d;
            b0_q    <= b0_d;
            a0_q    <= a0_d;
            b1_q    <= b1_d;
            a1_q    <= a1_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a queue-based slot model.
module tb_fetch_unit;

    localparam logic [15:0] TOP = 16'h0FFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        EA;
    logic        load;
    logic [15:0] load_addr;
    logic [7:0]  out_byte;
    logic [15:0] out_addr;
    logic        out_valid;
    logic        out_ready;
    logic        ALE;
    logic        PSEN;
    logic [7:0]  p0_out;
    logic        p0_oe;
    logic [7:0]  p0_in;
    logic [7:0]  p2_out;
    logic        p2_oe;
    logic [15:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_data;

    fetch_unit #(.SLOT_CLKS(6), .IROM_TOP(TOP)) dut (
        .clk(clk), .reset(reset), .EA(EA), .load(load), .load_addr(load_addr),
        .out_byte(out_byte), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .ALE(ALE), .PSEN(PSEN), .p0_out(p0_out),
        .p0_oe(p0_oe), .p0_in(p0_in), .p2_out(p2_out), .p2_oe(p2_oe),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: slot phase (-1 idle, 0..5 active), latched mode,
    // fetch address and a queue of {byte, address} entries.
    typedef struct packed {
        logic [7:0]  b;
        logic [15:0] a;
    } ent_t;

    int          m_ph;
    bit          m_int;
    logic [15:0] m_addr;
    ent_t        m_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic model_clear();
        m_ph   = -1;
        m_int  = 1'b0;
        m_addr = 16'h0000;
        m_q.delete();
    endtask

    task automatic model_update();
        ent_t e;
        bit   pop;
        if (!reset) begin
            model_clear();
            return;
        end
        if (load) begin
            m_q.delete();
            m_addr = load_addr;
            m_ph   = -1;
            return;
        end
        pop = (m_q.size() > 0) && out_ready;
        if (m_ph == -1) begin
            if (m_q.size() < 2) m_ph = 0;
        end else if (m_ph == 0) begin
            m_int = EA && (m_addr <= TOP);
            m_ph  = 1;
        end else if (m_ph < 5) begin
            m_ph++;
        end else begin
            e.b = m_int ? rom_data : p0_in;
            e.a = m_addr;
            if (pop) void'(m_q.pop_front());
            pop = 1'b0;
            m_q.push_back(e);
            m_addr++;
            m_ph = (m_q.size() < 2) ? 0 : -1;
        end
        if (pop) void'(m_q.pop_front());
    endtask

    task automatic check_outputs();
        bit act, intl, e_valid;
        act     = (m_ph >= 0);
        intl    = (m_ph == 0) ? (EA && (m_addr <= TOP)) : m_int;
        e_valid = (m_q.size() > 0);
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        if (e_valid) begin
            chk("out_byte", 32'(out_byte), 32'(m_q[0].b));
            chk("out_addr", 32'(out_addr), 32'(m_q[0].a));
        end
        chk("ALE", 32'(ALE), 32'(m_ph == 0 || m_ph == 1));
        chk("PSEN", 32'(PSEN), 32'(!(act && !intl && m_ph >= 3)));
        chk("p0_oe", 32'(p0_oe), 32'(act && !intl && m_ph <= 2));
        chk("p2_oe", 32'(p2_oe), 32'(act && !intl));
        chk("rom_rd", 32'(rom_rd), 32'(act && intl && m_ph >= 3));
        if (act && !intl && m_ph <= 2) chk("p0_out", 32'(p0_out), 32'(m_addr[7:0]));
        if (act && !intl) chk("p2_out", 32'(p2_out), 32'(m_addr[15:8]));
        if (act && intl) chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    endtask

    // Called just after a negedge with inputs already applied.
    task automatic settle_check();
        #1;
        check_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic reset_literals(input string tag);
        chk({tag, "_psen"}, 32'(PSEN), 32'd1);
        chk({tag, "_ale"}, 32'(ALE), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_p0oe"}, 32'(p0_oe), 32'd0);
        chk({tag, "_p2oe"}, 32'(p2_oe), 32'd0);
        chk({tag, "_romrd"}, 32'(rom_rd), 32'd0);
        chk({tag, "_obyte"}, 32'(out_byte), 32'h00);
        chk({tag, "_oaddr"}, 32'(out_addr), 32'h0000);
        chk({tag, "_romaddr"}, 32'(rom_addr), 32'h0000);
    endtask

    // Leaves the bench just after a negedge with reset released and FSM idle.
    task automatic do_reset();
        reset = 1'b0;
        load  = 1'b0;
        #1;
        model_clear();
        advance();
        advance();
        reset = 1'b1;
    endtask

    int ale_cnt, psen_cnt, rd_cnt, oe_cnt;

    initial begin
        reset = 1'b0; EA = 1'b0; load = 1'b0; load_addr = 16'h0000;
        out_ready = 1'b0; p0_in = 8'h00; rom_data = 8'h00;
        model_clear();
        @(negedge clk);

        // External fetch of 0x75 at address 0.
        do_reset();
        reset_literals("rst0");
        EA = 1'b0; out_ready = 1'b1; p0_in = 8'h75;
        ale_cnt = 0; psen_cnt = 0;
        for (int k = 0; k <= 7; k++) begin
            settle_check();
            if (k >= 1 && k <= 6) begin
                ale_cnt  += int'(ALE);
                psen_cnt += int'(!PSEN);
            end
            if (k == 1) begin
                chk("t1_p0_s0", 32'(p0_out), 32'h00);
                chk("t1_p2_s0", 32'(p2_out), 32'h00);
            end
            if (k == 6) chk("t1_latency", 32'(out_valid), 32'd0);
            if (k == 7) begin
                chk("t1_byte", 32'(out_byte), 32'h75);
                chk("t1_addr", 32'(out_addr), 32'h0000);
                chk("t1_next_p0", 32'(p0_out), 32'h01);
                chk("t1_next_ale", 32'(ALE), 32'd1);
            end
            advance();
        end
        chk("t1_ale_clks", 32'(ale_cnt), 32'd2);
        chk("t1_psen_clks", 32'(psen_cnt), 32'd3);

        // Internal ROM fetch of 0xE4 at address 0.
        do_reset();
        EA = 1'b1; out_ready = 1'b1; rom_data = 8'hE4; p0_in = 8'h11;
        psen_cnt = 0; rd_cnt = 0; oe_cnt = 0;
        for (int k = 0; k <= 7; k++) begin
            settle_check();
            if (k >= 1 && k <= 6) begin
                psen_cnt += int'(!PSEN);
                rd_cnt   += int'(rom_rd);
                oe_cnt   += int'(p0_oe);
            end
            if (k == 7) chk("t2_byte", 32'(out_byte), 32'hE4);
            advance();
        end
        chk("t2_psen_low", 32'(psen_cnt), 32'd0);
        chk("t2_rd_clks", 32'(rd_cnt), 32'd3);
        chk("t2_p0oe", 32'(oe_cnt), 32'd0);

        // Load 0x0FFF: internal fetch, then 0x1000 goes external.
        do_reset();
        EA = 1'b1; out_ready = 1'b1; rom_data = 8'hA5; p0_in = 8'h5A;
        load = 1'b1; load_addr = 16'h0FFF;
        settle_check();
        advance();
        load = 1'b0;
        for (int j = 0; j <= 10; j++) begin
            settle_check();
            if (j == 1) chk("t3_int_p0oe", 32'(p0_oe), 32'd0);
            if (j == 4) begin
                chk("t3_rom_rd", 32'(rom_rd), 32'd1);
                chk("t3_rom_addr", 32'(rom_addr), 32'h0FFF);
            end
            if (j == 7) begin
                chk("t3_p2", 32'(p2_out), 32'h10);
                chk("t3_p2oe", 32'(p2_oe), 32'd1);
                chk("t3_first_byte", 32'(out_byte), 32'hA5);
            end
            if (j == 10) chk("t3_psen", 32'(PSEN), 32'd0);
            advance();
        end

        // Back-pressure: two bytes then idle; one pop starts one new slot.
        do_reset();
        EA = 1'b0; out_ready = 1'b0; p0_in = 8'h42;
        ale_cnt = 0;
        for (int k = 0; k <= 24; k++) begin
            out_ready = (k == 20);
            settle_check();
            if (k >= 13 && k <= 19) ale_cnt += int'(ALE);
            if (k == 19) chk("t4_head", 32'(out_addr), 32'h0000);
            if (k == 21) begin
                chk("t4_after_pop", 32'(out_addr), 32'h0001);
                chk("t4_idle_ale", 32'(ALE), 32'd0);
            end
            if (k == 22) begin
                chk("t4_restart_ale", 32'(ALE), 32'd1);
                chk("t4_restart_p0", 32'(p0_out), 32'h02);
            end
            advance();
        end
        chk("t4_no_ale_full", 32'(ale_cnt), 32'd0);

        // Load 0xFFFF during S4: abort, then fetch 0xFFFF and 0x0000.
        do_reset();
        EA = 1'b0; out_ready = 1'b0; p0_in = 8'h3C;
        for (int k = 0; k <= 13; k++) begin
            load = (k == 5);
            load_addr = 16'hFFFF;
            settle_check();
            if (k == 5) chk("t5_psen_s4", 32'(PSEN), 32'd0);
            if (k == 6) begin
                chk("t5_psen_abort", 32'(PSEN), 32'd1);
                chk("t5_ale_abort", 32'(ALE), 32'd0);
                chk("t5_valid_abort", 32'(out_valid), 32'd0);
                chk("t5_p2oe_abort", 32'(p2_oe), 32'd0);
            end
            if (k == 7) begin
                chk("t5_p2_ffff", 32'(p2_out), 32'hFF);
                chk("t5_p0_ffff", 32'(p0_out), 32'hFF);
            end
            if (k == 13) begin
                chk("t5_wrap_p2", 32'(p2_out), 32'h00);
                chk("t5_wrap_p0", 32'(p0_out), 32'h00);
                chk("t5_head_addr", 32'(out_addr), 32'hFFFF);
                chk("t5_head_byte", 32'(out_byte), 32'h3C);
            end
            advance();
        end
        load = 1'b0;

        // Asynchronous reset during S4 of the second slot.
        do_reset();
        EA = 1'b0; out_ready = 1'b0; p0_in = 8'h99;
        for (int k = 0; k <= 10; k++) begin
            settle_check();
            advance();
        end
        settle_check();
        chk("t6_psen_s4", 32'(PSEN), 32'd0);
        chk("t6_valid_pre", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        reset_literals("t6_async");
        model_clear();
        advance();
        reset = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            settle_check();
            if (k == 1) begin
                chk("t6_restart_ale", 32'(ALE), 32'd1);
                chk("t6_restart_p0", 32'(p0_out), 32'h00);
            end
            if (k == 7) chk("t6_restart_addr", 32'(out_addr), 32'h0000);
            advance();
        end

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            EA        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            p0_in     = 8'($urandom_range(0, 255));
            rom_data  = 8'($urandom_range(0, 255));
            load      = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 4))
                0: load_addr = 16'h0FFE;
                1: load_addr = 16'h0FFF;
                2: load_addr = 16'hFFFE;
                3: load_addr = 16'h1000;
                default: load_addr = 16'($urandom_range(0, 65535));
            endcase
            settle_check();
            advance();
        end
        load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
